// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator motion controller: FSM states, default
// sizing and the SCAN helpers that look for outstanding calls above/below a floor.
package elevador_pkg;

  typedef enum logic [2:0] {
    PARADO,
    ABRINDO,
    ESPERA,
    FECHANDO,
    MOVENDO
  } estado_t;

  localparam int N_ANDARES_PADRAO = 4;
  localparam int T_ANDAR_PADRAO   = 8;
  localparam int T_ESPERA_PADRAO  = 6;

  // Helpers take a zero-extended call vector so any building height up to N_MAX fits.
  localparam int N_MAX = 32;

  function automatic logic ha_acima(input logic [N_MAX-1:0] pend, input int andar);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_MAX; i++) begin
      if (pend[i] && (i > andar)) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic ha_abaixo(input logic [N_MAX-1:0] pend, input int andar);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_MAX; i++) begin
      if (pend[i] && (i < andar)) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/controle_andares_contador.sv
// Loadable down-counter that saturates at zero; used for both travel time
// and door dwell time.
module contador_carga #(
  parameter int LARGURA = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_carga,
  input  logic [LARGURA-1:0] i_valor,
  input  logic               i_dec,
  output logic               o_zero
);

  logic [LARGURA-1:0] r_valor;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valor <= '0;
    end else if (i_carga) begin
      r_valor <= i_valor;
    end else if (i_dec && (r_valor != '0)) begin
      r_valor <= r_valor - 1'b1;
    end
  end

  assign o_zero = (r_valor == '0);

endmodule

// File: rtl/controle_andares.sv
// Elevator motion/dispatch controller: latches floor calls, picks direction with
// SCAN, times travel between floors and steps the door block.
module controle_andares
  import elevador_pkg::*;
#(
  parameter int  N_ANDARES = N_ANDARES_PADRAO,
  parameter int  T_ANDAR   = T_ANDAR_PADRAO,
  parameter int  T_ESPERA  = T_ESPERA_PADRAO,
  localparam int W         = $clog2(N_ANDARES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_ANDARES-1:0] req,
  input  logic                 fechada,
  input  logic                 cheio,
  output logic                 porta_en,
  output logic [W-1:0]         andar_atual,
  output logic                 subindo,
  output logic                 descendo,
  output logic                 chegou,
  output logic [N_ANDARES-1:0] pendentes
);

  localparam int WC = $clog2(((T_ANDAR > T_ESPERA) ? T_ANDAR : T_ESPERA) + 1);

  estado_t              r_estado;
  logic [W-1:0]         r_andar;
  logic                 r_subindo;
  logic                 r_descendo;
  logic                 r_porta_en;
  logic                 r_chegou;
  logic [N_ANDARES-1:0] r_pendentes;

  logic [N_ANDARES-1:0] w_pend_vis;
  logic [N_ANDARES-1:0] w_clr;
  logic [W-1:0]         w_prox;
  logic                 w_zero_v;
  logic                 w_zero_e;
  logic                 w_expira;
  logic                 w_chegada;
  logic                 w_adiante;
  logic                 w_segue;
  logic                 w_sobe;
  logic                 w_parte;
  logic                 w_recarga;
  logic                 w_carga_v;
  logic                 w_dec_v;
  logic                 w_carga_e;
  logic                 w_dec_e;

  // A call arriving in the same cycle as the floor update counts as an arrival.
  assign w_pend_vis = r_pendentes | req;
  assign w_clr      = ((r_estado == ABRINDO) || (r_estado == ESPERA)) ?
                      (N_ANDARES'(1) << r_andar) : '0;
  assign w_prox     = r_subindo ? (r_andar + 1'b1) : (r_andar - 1'b1);

  assign w_expira  = (r_estado == MOVENDO) && fechada && w_zero_v;
  assign w_chegada = w_expira && w_pend_vis[w_prox];
  assign w_adiante = r_subindo ? ha_acima(N_MAX'(w_pend_vis), int'(w_prox))
                               : ha_abaixo(N_MAX'(w_pend_vis), int'(w_prox));
  assign w_segue   = w_expira && !w_chegada && w_adiante;

  // Keep heading down while calls remain below; otherwise prefer up.
  assign w_sobe  = (r_descendo && ha_abaixo(N_MAX'(r_pendentes), int'(r_andar))) ? 1'b0 :
                   ha_acima(N_MAX'(r_pendentes), int'(r_andar));
  assign w_parte = (r_estado == PARADO) && !r_pendentes[r_andar] && fechada && (|r_pendentes);

  assign w_recarga = (r_estado == ESPERA) && (cheio || req[r_andar]);

  assign w_carga_v = w_parte || w_segue;
  assign w_dec_v   = (r_estado == MOVENDO) && fechada;
  assign w_carga_e = ((r_estado == ABRINDO) && !fechada) || w_recarga;
  assign w_dec_e   = (r_estado == ESPERA);

  contador_carga #(.LARGURA(WC)) u_viagem (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_carga (w_carga_v),
    .i_valor (WC'(T_ANDAR - 1)),
    .i_dec   (w_dec_v),
    .o_zero  (w_zero_v)
  );

  contador_carga #(.LARGURA(WC)) u_espera (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_carga (w_carga_e),
    .i_valor (WC'(T_ESPERA - 1)),
    .i_dec   (w_dec_e),
    .o_zero  (w_zero_e)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_estado    <= PARADO;
      r_andar     <= '0;
      r_subindo   <= 1'b0;
      r_descendo  <= 1'b0;
      r_porta_en  <= 1'b0;
      r_chegou    <= 1'b0;
      r_pendentes <= '0;
    end else begin
      r_pendentes <= w_pend_vis & ~w_clr;
      r_chegou    <= 1'b0;
      case (r_estado)
        PARADO: begin
          if (r_pendentes[r_andar]) begin
            r_estado   <= ABRINDO;
            r_porta_en <= 1'b1;
          end else if (!fechada) begin
            r_estado   <= FECHANDO;
            r_porta_en <= 1'b1;
          end else if (w_parte) begin
            r_estado   <= MOVENDO;
            r_subindo  <= w_sobe;
            r_descendo <= !w_sobe;
            r_porta_en <= 1'b0;
          end else begin
            r_subindo  <= 1'b0;
            r_descendo <= 1'b0;
            r_porta_en <= 1'b0;
          end
        end
        ABRINDO: begin
          if (!fechada) begin
            r_estado   <= ESPERA;
            r_porta_en <= 1'b0;
          end else begin
            r_porta_en <= 1'b1;
          end
        end
        ESPERA: begin
          r_porta_en <= 1'b0;
          if (!w_recarga && w_zero_e) begin
            r_estado   <= FECHANDO;
            r_porta_en <= 1'b1;
          end
        end
        FECHANDO: begin
          if (cheio) begin
            r_estado   <= ABRINDO;
            r_porta_en <= 1'b1;
          end else if (fechada) begin
            r_estado   <= PARADO;
            r_porta_en <= 1'b0;
          end else begin
            r_porta_en <= 1'b1;
          end
        end
        MOVENDO: begin
          // An open door here is a fault: the travel counter is frozen by w_dec_v.
          r_porta_en <= 1'b0;
          if (w_expira) begin
            r_andar <= w_prox;
            if (w_chegada) begin
              r_chegou   <= 1'b1;
              r_estado   <= ABRINDO;
              r_porta_en <= 1'b1;
            end else if (!w_segue) begin
              r_estado <= PARADO;
            end
          end
        end
        default: begin
          r_estado   <= PARADO;
          r_porta_en <= 1'b0;
        end
      endcase
    end
  end

  a_movendo_fechada: assert property (@(posedge clk) disable iff (!reset)
    (r_estado == MOVENDO) |-> fechada);

  a_limites: assert property (@(posedge clk) disable iff (!reset)
    w_expira |-> (r_subindo ? (r_andar != W'(N_ANDARES - 1)) : (r_andar != '0)));

  assign porta_en    = r_porta_en;
  assign andar_atual = r_andar;
  assign subindo     = r_subindo;
  assign descendo    = r_descendo;
  assign chegou      = r_chegou;
  assign pendentes   = r_pendentes;

endmodule

// File: tb/tb_controle_andares.sv
// Bench for controle_andares with a simple two-step door model and an arrival scoreboard.
module tb_controle_andares;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         fechada;
  logic         cheio;
  logic         porta_en;
  logic [W-1:0] andar_atual;
  logic         subindo;
  logic         descendo;
  logic         chegou;
  logic [N-1:0] pendentes;

  typedef struct {
    logic [W-1:0] andar;
    logic         sub;
    logic         desc;
  } chegada_t;

  chegada_t sb[$];
  int checks   = 0;
  int failures = 0;

  controle_andares #(.N_ANDARES(N), .T_ANDAR(8), .T_ESPERA(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .fechada     (fechada),
    .cheio       (cheio),
    .porta_en    (porta_en),
    .andar_atual (andar_atual),
    .subindo     (subindo),
    .descendo    (descendo),
    .chegou      (chegou),
    .pendentes   (pendentes)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arrival scoreboard plus door model: two consecutive enabled steps toggle the door.
  initial begin : observador
    int cnt;
    chegada_t e;
    cnt = 0;
    fechada = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (chegou === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL chegada_extra andar=%0d esperado=nenhuma", andar_atual);
        end else begin
          e = sb.pop_front();
          if (andar_atual !== e.andar || subindo !== e.sub || descendo !== e.desc) begin
            failures++;
            $display("FAIL chegada andar=%0d sub=%0b desc=%0b esperado andar=%0d sub=%0b desc=%0b",
                     andar_atual, subindo, descendo, e.andar, e.sub, e.desc);
          end
        end
      end
      @(negedge clk);
      if (porta_en === 1'b1) begin
        cnt++;
        if (cnt >= 2) begin
          fechada = ~fechada;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({andar_atual, porta_en, subindo, descendo, chegou, pendentes} !== 9'b0) begin
      failures++;
      $display("FAIL reset_estado andar=%0d porta=%0b sub=%0b desc=%0b chegou=%0b pend=%b esperado=todos_zero",
               andar_atual, porta_en, subindo, descendo, chegou, pendentes);
    end
    reset = 1'b1;
    repeat (4) tick();
    checks++;
    if ({andar_atual, porta_en, subindo, descendo, chegou, pendentes} !== 9'b0) begin
      failures++;
      $display("FAIL reset_parado andar=%0d porta=%0b sub=%0b desc=%0b pend=%b esperado=todos_zero",
               andar_atual, porta_en, subindo, descendo, pendentes);
    end
  endtask

  task automatic test_subida();
    logic ok;
    req = 4'b0100;
    sb.push_back('{2'd2, 1'b1, 1'b0});
    tick();
    checks++;
    if (pendentes !== 4'b0100) begin
      failures++;
      $display("FAIL subida_latch pend=%b esperado=0100", pendentes);
    end
    req = '0;
    tick();
    checks++;
    if (subindo !== 1'b1 || descendo !== 1'b0 || andar_atual !== 2'd0 || porta_en !== 1'b0) begin
      failures++;
      $display("FAIL subida_partida sub=%0b desc=%0b andar=%0d porta=%0b esperado sub=1 desc=0 andar=0 porta=0",
               subindo, descendo, andar_atual, porta_en);
    end
    repeat (7) tick();
    checks++;
    if (andar_atual !== 2'd0) begin
      failures++;
      $display("FAIL subida_t7 andar=%0d esperado=0", andar_atual);
    end
    tick();
    checks++;
    if (andar_atual !== 2'd1) begin
      failures++;
      $display("FAIL subida_t8 andar=%0d esperado=1", andar_atual);
    end
    repeat (7) tick();
    checks++;
    if (andar_atual !== 2'd1) begin
      failures++;
      $display("FAIL subida_t15 andar=%0d esperado=1", andar_atual);
    end
    tick();
    checks++;
    if (andar_atual !== 2'd2 || chegou !== 1'b1 || porta_en !== 1'b1) begin
      failures++;
      $display("FAIL subida_t16 andar=%0d chegou=%0b porta=%0b esperado andar=2 chegou=1 porta=1",
               andar_atual, chegou, porta_en);
    end
    tick();
    checks++;
    if (chegou !== 1'b0 || pendentes !== 4'b0000) begin
      failures++;
      $display("FAIL subida_limpa chegou=%0b pend=%b esperado chegou=0 pend=0000", chegou, pendentes);
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fechada === 1'b0) begin
        ok = 1'b1;
        break;
      end
      checks++;
      if (porta_en !== 1'b1) begin
        failures++;
        $display("FAIL subida_abrindo porta=%0b esperado=1", porta_en);
      end
      tick();
    end
    checks++;
    if (!ok || porta_en !== 1'b0) begin
      failures++;
      $display("FAIL subida_espera aberta=%0b porta=%0b esperado aberta=1 porta=0", ok, porta_en);
    end
  endtask

  task automatic test_cheio();
    logic ok;
    cheio = 1'b1;
    repeat (20) begin
      tick();
      checks++;
      if (porta_en !== 1'b0) begin
        failures++;
        $display("FAIL cheio_segura porta=%0b esperado=0", porta_en);
      end
    end
    cheio = 1'b0;
    repeat (5) begin
      tick();
      checks++;
      if (porta_en !== 1'b0) begin
        failures++;
        $display("FAIL cheio_contagem porta=%0b esperado=0", porta_en);
      end
    end
    tick();
    checks++;
    if (porta_en !== 1'b1) begin
      failures++;
      $display("FAIL cheio_fecha porta=%0b esperado=1", porta_en);
    end
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (fechada && !porta_en && !subindo && !descendo && pendentes == '0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || andar_atual !== 2'd2) begin
      failures++;
      $display("FAIL cheio_ocioso ocioso=%0b andar=%0d esperado ocioso=1 andar=2", ok, andar_atual);
    end
  endtask

  task automatic test_descida();
    logic ok;
    req = 4'b0001;
    sb.push_back('{2'd0, 1'b0, 1'b1});
    tick();
    req = '0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL descida_timeout restantes=%0d esperado=0", sb.size());
    end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (fechada && !porta_en && !subindo && !descendo && pendentes == '0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || andar_atual !== 2'd0) begin
      failures++;
      $display("FAIL descida_ocioso ocioso=%0b andar=%0d esperado ocioso=1 andar=0", ok, andar_atual);
    end
  endtask

  task automatic test_scan();
    logic ok;
    req = 4'b1000;
    sb.push_back('{2'd3, 1'b1, 1'b0});
    tick();
    req = '0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (andar_atual === 2'd1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || subindo !== 1'b1) begin
      failures++;
      $display("FAIL scan_andar1 andar=%0d sub=%0b esperado andar=1 sub=1", andar_atual, subindo);
    end
    req = 4'b0001;
    sb.push_back('{2'd0, 1'b0, 1'b1});
    tick();
    req = '0;
    checks++;
    if (pendentes !== 4'b1001) begin
      failures++;
      $display("FAIL scan_pendentes pend=%b esperado=1001", pendentes);
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL scan_timeout restantes=%0d esperado=0", sb.size());
    end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (fechada && !porta_en && !subindo && !descendo && pendentes == '0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || andar_atual !== 2'd0) begin
      failures++;
      $display("FAIL scan_ocioso ocioso=%0b andar=%0d esperado ocioso=1 andar=0", ok, andar_atual);
    end
  endtask

  task automatic test_reabre();
    logic ok;
    req = 4'b0001;
    tick();
    req = '0;
    checks++;
    if (pendentes !== 4'b0001 || porta_en !== 1'b0) begin
      failures++;
      $display("FAIL reabre_latch pend=%b porta=%0b esperado pend=0001 porta=0", pendentes, porta_en);
    end
    tick();
    checks++;
    if (porta_en !== 1'b1) begin
      failures++;
      $display("FAIL reabre_latencia porta=%0b esperado=1", porta_en);
    end
    tick();
    checks++;
    if (pendentes !== 4'b0000) begin
      failures++;
      $display("FAIL reabre_limpa pend=%b esperado=0000", pendentes);
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fechada === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok || porta_en !== 1'b0) begin
      failures++;
      $display("FAIL reabre_espera aberta=%0b porta=%0b esperado aberta=1 porta=0", ok, porta_en);
    end
    repeat (3) tick();
    req = 4'b0001;
    tick();
    req = '0;
    checks++;
    if (pendentes !== 4'b0000 || porta_en !== 1'b0) begin
      failures++;
      $display("FAIL reabre_absorve pend=%b porta=%0b esperado pend=0000 porta=0", pendentes, porta_en);
    end
    repeat (5) begin
      tick();
      checks++;
      if (porta_en !== 1'b0) begin
        failures++;
        $display("FAIL reabre_recarga porta=%0b esperado=0", porta_en);
      end
    end
    tick();
    checks++;
    if (porta_en !== 1'b1) begin
      failures++;
      $display("FAIL reabre_fecha porta=%0b esperado=1", porta_en);
    end
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (fechada && !porta_en && !subindo && !descendo && pendentes == '0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reabre_ocioso ocioso=%0b esperado=1", ok);
    end
  endtask

  task automatic test_reset_movendo();
    logic ok;
    req = 4'b1000;
    sb.push_back('{2'd3, 1'b1, 1'b0});
    tick();
    req = '0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (andar_atual === 2'd1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rstmov_andar1 andar=%0d esperado=1", andar_atual);
    end
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({andar_atual, porta_en, subindo, descendo, chegou, pendentes} !== 9'b0) begin
      failures++;
      $display("FAIL rstmov_aborta andar=%0d porta=%0b sub=%0b desc=%0b chegou=%0b pend=%b esperado=todos_zero",
               andar_atual, porta_en, subindo, descendo, chegou, pendentes);
    end
    reset = 1'b1;
    sb.delete();
    repeat (12) tick();
    checks++;
    if (andar_atual !== 2'd0 || subindo !== 1'b0 || porta_en !== 1'b0) begin
      failures++;
      $display("FAIL rstmov_parado andar=%0d sub=%0b porta=%0b esperado andar=0 sub=0 porta=0",
               andar_atual, subindo, porta_en);
    end
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    cheio = 1'b0;
    test_reset();
    test_subida();
    test_cheio();
    test_descida();
    test_scan();
    test_reabre();
    test_reset_movendo();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_restante restantes=%0d esperado=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controle_andares.md
Name: controle_andares

Overview:
- Elevator motion/dispatch controller, directly upstream of the door state machine.
- Latches floor-call buttons and chooses a direction with SCAN (keep direction while calls exist ahead).
- Times inter-floor travel and drives the door module's step-enable.
- Consumes the door's fechada and the cabin overload flag cheio; motion is never permitted unless fechada=1.

Parameters:
- N_ANDARES, 4, number of floors (>=2); floor indices 0..N_ANDARES-1.
- T_ANDAR, 8, clock cycles to travel one floor.
- T_ESPERA, 6, clock cycles the door dwells open before closing.
- W, $clog2(N_ANDARES), width of floor index (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  N_ANDARES  floor-call buttons, one bit per floor, level or pulse.
- fechada  in  1  door status from door block, 1 = closed.
- cheio  in  1  cabin overload; door must stay/return open.
- porta_en  out  1  step-enable to door block.
- andar_atual  out  W  current floor.
- subindo  out  1  moving or committed upward.
- descendo  out  1  moving or committed downward.
- chegou  out  1  one-cycle pulse on arrival at a served floor.
- pendentes  out  N_ANDARES  latched outstanding calls.

Behaviour:
- Reset (reset=0 at clk edge):
  - state=PARADO; andar_atual=0; subindo=descendo=0; porta_en=0; chegou=0; pendentes=0; counters=0.
  - Reset mid-travel aborts without a floor update.
- Call latch, every cycle:
  - pendentes <= (pendentes | req) & ~clr.
  - clr = onehot(andar_atual) in ABRINDO and ESPERA.
  - A call for the current floor while the door is open is absorbed and reloads the dwell counter.
- States:
  - PARADO: if pendentes[andar_atual] -> ABRINDO. Else if fechada=0 -> FECHANDO. Else if any pendentes -> pick direction (up if any call above, else down) -> MOVENDO when fechada=1. Else stay with subindo=descendo=0.
  - ABRINDO: porta_en=1 until fechada=0, then -> ESPERA with dwell counter=T_ESPERA-1.
  - ESPERA: porta_en=0. Counter decrements to 0, then -> FECHANDO. cheio=1 or req[andar_atual]=1 reloads the counter to T_ESPERA-1.
  - FECHANDO: porta_en=1 until fechada=1, then -> PARADO. cheio=1 while closing -> ABRINDO.
  - MOVENDO: travel counter runs T_ANDAR cycles.
    - On expiry, andar_atual += subindo ? 1 : -1.
    - If pendentes[new floor]: chegou=1 for that cycle -> ABRINDO.
    - Else continue if calls remain ahead.
    - Else stop -> PARADO (re-evaluate, possibly reversing).
- Direction (SCAN):
  - Keep the current direction while any pendentes bit exists strictly ahead.
  - Reverse only when none are ahead.
  - Clear subindo/descendo in PARADO when pendentes=0.
- Bounds: never increment past N_ANDARES-1 or decrement below 0. Direction selection guarantees this; an assertion checks it.
- Latency:
  - Call at the current floor in PARADO with door closed: porta_en rises 1 cycle after the call is latched.
  - Travel between adjacent floors = T_ANDAR cycles from MOVENDO entry to andar_atual update.
- Safety invariant: state MOVENDO implies fechada=1. If fechada drops during MOVENDO, freeze the counter and hold porta_en=0. This is a fault hold with no movement; an assertion flags it.
- Simultaneous events:
  - cheio has priority over dwell expiry.
  - Arrival and a new call at the same floor in the same cycle are treated as an arrival.

Decomposition:
- Shared package elevador_pkg holds:
  - state enum (PARADO, ABRINDO, ESPERA, FECHANDO, MOVENDO);
  - default N_ANDARES, T_ANDAR, T_ESPERA;
  - functions ha_acima(pendentes, andar) and ha_abaixo(pendentes, andar).
- One natural sub-module, contador_carga: a loadable down-counter with zero flag, instanced twice (travel and dwell).

Test Plan:
- Reset with fechada=1, no req -> andar_atual=0, porta_en=0, pendentes=0, stays PARADO.
- At floor 0, pulse req[2] -> MOVENDO up. andar_atual=1 after 8 cycles, 2 after 16. chegou pulses at floor 2; pendentes[2] clears; porta_en=1 until fechada=0.
- Door open at floor 2 in ESPERA, hold cheio=1 for 20 cycles -> no FECHANDO; closing starts 6 cycles after cheio falls.
- At floor 1 going up with req[3] and req[0] pending -> serves 3 first, then reverses to 0. Arrival order 3 then 0; subindo then descendo.
- req[andar_atual] asserted in ESPERA -> dwell restarts at 6; pendentes bit stays 0.
- Reset asserted mid-MOVENDO -> next cycle andar_atual=0, subindo=0, porta_en=0, pendentes=0.
